rtype_exec_ctrl: RTL and testbench
==================================

Name: rtype_exec_ctrl

Overview:
Multi-cycle sequencer that executes one MIPS R-type ALU instruction (add, sub, and, or, slt) or one beq comparison at a time. It drives the register file read ports and the ALU. It captures the ALU result and writes it back to the register file. It sits between the instruction source and the regfile/ALU pair, and is the first step toward the full multi-cycle control unit.

Parameters:
DATA_W, 32, datapath width of operands and results
REG_AW, 5, register address width (32 registers)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
instr_valid  in  1  instruction offered
instr_ready  out  1  controller idle, can accept
instr  in  32  MIPS instruction word
rf_ra1  out  REG_AW  regfile read address 1 (rs)
rf_ra2  out  REG_AW  regfile read address 2 (rt)
rf_rd1  in  DATA_W  regfile read data 1, combinational from rf_ra1
rf_rd2  in  DATA_W  regfile read data 2, combinational from rf_ra2
rf_we  out  1  regfile write enable
rf_wa  out  REG_AW  regfile write address (rd)
rf_wd  out  DATA_W  regfile write data
alu_op  out  3  ALU function: AND 000, OR 001, ADD 010, SUB 110, SLT 111
alu_a  out  DATA_W  ALU operand a
alu_b  out  DATA_W  ALU operand b
alu_x  in  DATA_W  ALU result, combinational
alu_zero  in  1  ALU zero flag, combinational
done  out  1  one-cycle completion pulse
branch_taken  out  1  registered status: last beq compared equal
illegal  out  1  registered status: last instruction unsupported

Behaviour:
- States: IDLE, DECODE, EXEC, WB. Every transition is unconditional except IDLE.
- IDLE: instr_ready=1. When instr_valid=1, instr is latched into IR and the state goes to DECODE. The same edge clears branch_taken and illegal. Otherwise the state stays in IDLE.
- DECODE: rf_ra1=IR[25:21] and rf_ra2=IR[20:16]. Operand registers A and B capture rf_rd1 and rf_rd2 at the end of the cycle. The legal flag and alu_op are registered from the decode. Next state is EXEC.
- Legal instructions:
  - opcode 0x00 with shamt==0 and funct 0x20 add -> 010, 0x22 sub -> 110, 0x24 and -> 000, 0x25 or -> 001, 0x2A slt -> 111.
  - opcode 0x04 beq -> 110.
  - Anything else is illegal, including an R-type with nonzero shamt.
- EXEC: alu_a=A, alu_b=B, alu_op=decoded op. ALUOut captures alu_x and Z captures alu_zero. For an illegal instruction, alu_op, alu_a and alu_b stay 0. Next state is WB.
- WB: done=1 for exactly this cycle. Next state is IDLE.
  - R-type legal with rd!=0: rf_we=1, rf_wa=IR[15:11], rf_wd=ALUOut.
  - rd==0: rf_we=0 (no write to $zero).
  - beq: rf_we=0; branch_taken <= Z at the end of the cycle.
  - illegal: rf_we=0; illegal <= 1 at the end of the cycle.
- Latency: accept on edge T, done high during the cycle after edge T+2, and instr_ready high again on the following cycle. Maximum throughput is one instruction per 4 cycles.
- Idle outputs: outside DECODE, rf_ra1 and rf_ra2 are 0. Outside EXEC, alu_op/a/b are 0. Outside WB, rf_we, rf_wa and rf_wd are 0.
- While busy, instr_valid is ignored and instr may change freely, because IR holds the accepted word.
- Reset: asynchronous. State goes to IDLE; IR, A, B, ALUOut, Z, branch_taken and illegal go to 0. All outputs are 0 except instr_ready=1. Reset asserted mid-instruction aborts it with no write and no done, even during WB.
- Arithmetic is done entirely in the ALU; the controller never alters operand width or sign.

Decomposition:
- Shared package: opcode constants (RTYPE 6'h00, BEQ 6'h04), funct constants (ADD, SUB, AND, OR, SLT), ALU op codes (000/001/010/110/111), and the state encoding (IDLE/DECODE/EXEC/WB, 2 bits).
- Sub-module alu_decoder: combinational. Inputs are opcode, funct and shamt; outputs are alu_op[2:0], is_rtype, is_beq and legal. It is reused later by the full control unit.

Test Plan:
- Write path: regfile r1=3, r2=1; send add r3,r1,r2 (0x00221820). Expect done 3 cycles after accept with rf_we=1, rf_wa=3, rf_wd=4, and alu_op=010 during EXEC.
- Compare path: r4=1, r5=4; send slt r6,r5,r4 (0x00A4302A). Expect rf_wd=0, rf_wa=6. Then slt r6,r4,r5 gives rf_wd=1.
- beq: r1=4, r2=4; send beq r1,r2,off (0x10220005). Expect rf_we=0 throughout, alu_op=110, and branch_taken=1 after done. With r2=1, expect branch_taken=0.
- Illegal and $zero: funct 0x21 (addu) gives illegal=1 after done and no write. Add with rd=0 gives done but rf_we=0. R-type add with shamt=1 gives illegal=1.
- Handshake: hold instr_valid=1 continuously with changing instr. Expect exactly one accept per 4 cycles, each using the word present on its accept edge.
- Reset: assert rst during EXEC. Expect immediate return to IDLE with all outputs 0 except instr_ready=1, no rf_we or done pulse, and normal completion of the next instruction after release.

Source files
------------

// File: rtl/rtype_exec_ctrl_pkg.sv
// rtype_exec_ctrl_pkg: shared opcode/funct/ALU-op constants and sequencer state encoding
package rtype_exec_ctrl_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2a;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;
  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXEC, S_WB} state_t;
endpackage

// File: rtl/rtype_exec_ctrl_alu_decoder.sv
// alu_decoder: maps opcode/funct/shamt to ALU function and instruction class
module alu_decoder
  import rtype_exec_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic [4:0] shamt,
  output logic [2:0] alu_op,
  output logic       is_rtype,
  output logic       is_beq,
  output logic       legal
);
  logic funct_ok;
  always_comb begin
    is_rtype = opcode == OP_RTYPE;
    is_beq   = opcode == OP_BEQ;
    funct_ok = funct == F_ADD || funct == F_SUB || funct == F_AND || funct == F_OR || funct == F_SLT;
    legal    = is_beq || (is_rtype && shamt == 5'd0 && funct_ok);
    alu_op   = is_beq           ? ALU_SUB :
               !is_rtype        ? ALU_AND :
               funct == F_ADD   ? ALU_ADD :
               funct == F_SUB   ? ALU_SUB :
               funct == F_OR    ? ALU_OR  :
               funct == F_SLT   ? ALU_SLT : ALU_AND;
  end
endmodule

// File: rtl/rtype_exec_ctrl.sv
// rtype_exec_ctrl: four-state sequencer running one R-type ALU op or beq compare
module rtype_exec_ctrl
  import rtype_exec_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instr,
  output logic [REG_AW-1:0] rf_ra1,
  output logic [REG_AW-1:0] rf_ra2,
  input  logic [DATA_W-1:0] rf_rd1,
  input  logic [DATA_W-1:0] rf_rd2,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_wa,
  output logic [DATA_W-1:0] rf_wd,
  output logic [2:0]        alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_x,
  input  logic              alu_zero,
  output logic              done,
  output logic              branch_taken,
  output logic              illegal
);
  state_t state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, aluout_q, aluout_d;
  logic [2:0] op_q, op_d;
  logic z_q, z_d, legal_q, legal_d, bt_q, bt_d, ill_q, ill_d;
  logic [2:0] dec_op;
  logic dec_rtype, dec_beq, dec_legal;
  alu_decoder u_dec (
    .opcode  (ir_q[31:26]),
    .funct   (ir_q[5:0]),
    .shamt   (ir_q[10:6]),
    .alu_op  (dec_op),
    .is_rtype(dec_rtype),
    .is_beq  (dec_beq),
    .legal   (dec_legal)
  );
  always_comb begin
    state_d = state_q;
    ir_d = ir_q;
    a_d = a_q;
    b_d = b_q;
    aluout_d = aluout_q;
    op_d = op_q;
    z_d = z_q;
    legal_d = legal_q;
    bt_d = bt_q;
    ill_d = ill_q;
    instr_ready = 1'b0;
    rf_ra1 = '0;
    rf_ra2 = '0;
    rf_we = 1'b0;
    rf_wa = '0;
    rf_wd = '0;
    alu_op = '0;
    alu_a = '0;
    alu_b = '0;
    done = 1'b0;
    case (state_q)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          ir_d = instr;
          bt_d = 1'b0;
          ill_d = 1'b0;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        rf_ra1 = ir_q[25:21];
        rf_ra2 = ir_q[20:16];
        a_d = rf_rd1;
        b_d = rf_rd2;
        op_d = dec_op;
        legal_d = dec_legal;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        alu_op = legal_q ? op_q : '0;
        alu_a = legal_q ? a_q : '0;
        alu_b = legal_q ? b_q : '0;
        aluout_d = alu_x;
        z_d = alu_zero;
        state_d = S_WB;
      end
      default: begin
        done = 1'b1;
        rf_we = legal_q && dec_rtype && ir_q[15:11] != 5'd0;
        rf_wa = rf_we ? ir_q[15:11] : '0;
        rf_wd = rf_we ? aluout_q : '0;
        bt_d = legal_q && dec_beq ? z_q : bt_q;
        ill_d = ill_q | ~legal_q;
        state_d = S_IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ir_q <= '0;
      a_q <= '0;
      b_q <= '0;
      aluout_q <= '0;
      op_q <= '0;
      z_q <= 1'b0;
      legal_q <= 1'b0;
      bt_q <= 1'b0;
      ill_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q <= ir_d;
      a_q <= a_d;
      b_q <= b_d;
      aluout_q <= aluout_d;
      op_q <= op_d;
      z_q <= z_d;
      legal_q <= legal_d;
      bt_q <= bt_d;
      ill_q <= ill_d;
    end
  end
  assign branch_taken = bt_q;
  assign illegal = ill_q;
endmodule

// File: tb/tb_rtype_exec_ctrl.sv
// tb_rtype_exec_ctrl: randomized and directed checks against an instruction-level model
module tb_rtype_exec_ctrl;
  logic clk = 0, rst = 1, instr_valid = 0, instr_ready;
  logic [31:0] instr = 0;
  logic [4:0] rf_ra1, rf_ra2, rf_wa;
  logic [31:0] rf_rd1, rf_rd2, rf_wd, alu_a, alu_b, alu_x;
  logic [2:0] alu_op;
  logic rf_we, alu_zero, done, branch_taken, illegal;
  logic [31:0] regs [32];
  int n_vec = 0, n_err = 0;
  rtype_exec_ctrl dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_x(alu_x), .alu_zero(alu_zero),
    .done(done), .branch_taken(branch_taken), .illegal(illegal)
  );
  always #5 clk = ~clk;
  assign rf_rd1 = regs[rf_ra1];
  assign rf_rd2 = regs[rf_ra2];
  always_comb begin
    case (alu_op)
      3'b000: alu_x = alu_a & alu_b;
      3'b001: alu_x = alu_a | alu_b;
      3'b010: alu_x = alu_a + alu_b;
      3'b110: alu_x = alu_a - alu_b;
      3'b111: alu_x = {31'd0, $signed(alu_a) < $signed(alu_b)};
      default: alu_x = 32'd0;
    endcase
  end
  assign alu_zero = alu_x == 32'd0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic model(input logic [31:0] w, output logic leg, output logic wr, output logic [2:0] eop,
                       output logic [31:0] res, output logic eq);
    logic [31:0] a, b;
    a = regs[w[25:21]];
    b = regs[w[20:16]];
    eq = a == b;
    leg = 1;
    res = 0;
    eop = 0;
    if (w[31:26] == 6'h04) eop = 3'b110;
    else if (w[31:26] != 0 || w[10:6] != 0) leg = 0;
    else
      case (w[5:0])
        6'h20: begin eop = 3'b010; res = a + b; end
        6'h22: begin eop = 3'b110; res = a - b; end
        6'h24: begin eop = 3'b000; res = a & b; end
        6'h25: begin eop = 3'b001; res = a | b; end
        6'h2a: begin eop = 3'b111; res = $signed(a) < $signed(b) ? 1 : 0; end
        default: leg = 0;
      endcase
    wr = leg && w[31:26] == 0 && w[15:11] != 0;
  endtask
  task automatic check_idle_outs(input string tag);
    chk({tag, "_ready"}, instr_ready, 1);
    chk({tag, "_outs"}, {rf_ra1, rf_ra2, rf_we, rf_wa, rf_wd, alu_op, alu_a, alu_b, done}, 0);
  endtask
  task automatic run(input logic [31:0] w);
    logic leg, wr, eq;
    logic [2:0] eop;
    logic [31:0] res;
    model(w, leg, wr, eop, res, eq);
    instr_valid = 1;
    instr = w;
    for (int i = 0; i < 8 && !instr_ready; i++) @(negedge clk);
    chk("accept_ready", instr_ready, 1);
    @(negedge clk);
    instr_valid = 0;
    instr = $urandom;
    chk("dec_ra", {rf_ra1, rf_ra2}, {w[25:21], w[20:16]});
    chk("dec_quiet", {instr_ready, done, rf_we, alu_op}, 0);
    @(negedge clk);
    chk("exec_op", alu_op, leg ? eop : 3'b000);
    chk("exec_a", alu_a, leg ? regs[w[25:21]] : 0);
    chk("exec_b", alu_b, leg ? regs[w[20:16]] : 0);
    chk("exec_quiet", {done, rf_we, rf_ra1, rf_ra2}, 0);
    @(negedge clk);
    chk("wb_done", done, 1);
    chk("wb_we", rf_we, wr);
    if (wr) begin
      chk("wb_wa", rf_wa, w[15:11]);
      chk("wb_wd", rf_wd, res);
    end
    chk("wb_quiet", {alu_op, rf_ra1, instr_ready}, 0);
    if (rf_we && rf_wa != 0) regs[rf_wa] = rf_wd;
    @(negedge clk);
    chk("post_ready", instr_ready, 1);
    chk("post_done", done, 0);
    chk("post_bt", branch_taken, leg && w[31:26] == 6'h04 && eq);
    chk("post_ill", illegal, !leg);
  endtask
  function automatic logic [31:0] rword(input logic [5:0] op, input int rs, input int rt, input int rd,
                                        input int sh, input logic [5:0] fn);
    return {op, rs[4:0], rt[4:0], rd[4:0], sh[4:0], fn};
  endfunction
  initial begin
    logic [5:0] fns [5];
    logic [31:0] w, q_res [$];
    logic [4:0] q_rd [$];
    int last_acc;
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
    for (int i = 0; i < 32; i++) regs[i] = i == 0 ? 0 : $urandom;
    #1;
    chk("rst_async", {branch_taken, illegal}, 0);
    check_idle_outs("rst");
    @(negedge clk);
    rst = 0;
    regs[1] = 3; regs[2] = 1;
    run(32'h00221820);
    chk("add_result_reg", regs[3], 4);
    regs[4] = 1; regs[5] = 4;
    run(32'h00A4302A);
    run(32'h0085302A);
    chk("slt_result_reg", regs[6], 1);
    regs[1] = 4; regs[2] = 4;
    run(32'h10220005);
    regs[2] = 1;
    run(32'h10220005);
    run(32'h00221821);
    run(32'h00220020);
    run(32'h00221860);
    check_idle_outs("idle");
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 5))
        0, 1, 2: w = rword(0, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), 0, fns[$urandom_range(0, 4)]);
        3: begin
          w = rword(6'h04, $urandom_range(0, 31), $urandom_range(0, 31), 0, 0, 0);
          w[15:0] = $urandom;
          if ($urandom_range(0, 1) == 1) w[20:16] = w[25:21];
        end
        4: w = $urandom;
        default: w = rword(0, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 3), fns[$urandom_range(0, 4)]);
      endcase
      run(w);
    end
    last_acc = -100;
    for (int i = 0; i < 28; i++) begin
      instr_valid = i < 20;
      instr = rword(0, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(1, 31), 0, 6'h20);
      if (rf_we) begin
        chk("hs_pending", q_res.size() > 0, 1);
        if (q_res.size() > 0) begin
          chk("hs_wa", rf_wa, q_rd.pop_front());
          chk("hs_wd", rf_wd, q_res.pop_front());
        end
        if (rf_wa != 0) regs[rf_wa] = rf_wd;
      end
      if (instr_ready && instr_valid) begin
        if (last_acc >= 0) chk("hs_gap", i - last_acc, 4);
        last_acc = i;
        q_res.push_back(regs[instr[25:21]] + regs[instr[20:16]]);
        q_rd.push_back(instr[15:11]);
      end
      @(negedge clk);
    end
    chk("hs_drained", q_res.size(), 0);
    regs[7] = 10; regs[8] = 10;
    run(32'h10E80001);
    instr_valid = 1;
    instr = 32'h00E84822;
    @(negedge clk);
    instr_valid = 0;
    @(negedge clk);
    chk("pre_rst_exec", alu_op, 3'b110);
    rst = 1;
    #1;
    chk("rst_mid_bt", {branch_taken, illegal}, 0);
    check_idle_outs("rst_mid");
    @(negedge clk);
    check_idle_outs("rst_hold");
    rst = 0;
    @(negedge clk);
    chk("rst_no_write", regs[9] == 0 && regs[7] == 10, regs[9] == 0);
    regs[10] = 5; regs[11] = 2;
    run(32'h014B6022);
    chk("after_rst_reg", regs[12], 3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
